inert_intf: RTL
===============

# inert_intf

Inertial front end between the SPI monarch and the heading/PID path. After reset it waits for NEMO power-up and writes the four NEMO configuration registers. It then services every NEMO data-ready interrupt by reading the 16-bit yaw rate (low byte, then high byte) and presents it with a one-cycle valid strobe. It sits upstream of the PID/MtrDrv chain and directly drives the SPI transaction interface whose NEMO-side completion the tour bench checks as `NEMO_setup`.

## Interface
- `FAST_SIM`, default 0: 1 shortens the power-up wait from 2^16 to 2^10 clocks.
- `clk` input 1: system clock, all logic rising-edge.
- `rst` input 1: synchronous reset, active-high (one clock; reset is synchronous and active-high).
- `INT` input 1: NEMO data-ready, asynchronous, level; stays high until the yaw registers are read.
- `done` input 1: one-cycle pulse from the SPI monarch; the current transaction is complete.
- `rd_data` input 16: SPI monarch read data; bits [7:0] valid on `done`.
- `wrt` output 1: one-cycle pulse that starts an SPI transaction.
- `cmd` output 16: SPI command word. Bits [15:8] hold the address, with bit 15 = read. Bits [7:0] hold the write data.
- `setup_done` output 1: high once all configuration writes have finished; sticky until reset.
- `yaw_rt` output 16: last assembled signed yaw rate, {high byte, low byte}.
- `vld` output 1: one-cycle strobe; `yaw_rt` has just been updated.

## Operation
- INT passes through a 2-flop synchronizer (`INT_ff2`) before use. It is never sampled raw.
- Power-up timer: 16-bit counter, cleared by reset, increments every clock while in INIT_WAIT. INIT_WAIT exits when the counter reaches all ones in bits [15:0] (FAST_SIM=0) or bits [9:0] (FAST_SIM=1).
- State machine states: INIT_WAIT, CFG_INT, CFG_ACC, CFG_GYR, CFG_RND, WAIT_INT, RD_L, RD_H.
- Transitions:
  - INIT_WAIT -> CFG_INT on timer terminal count.
  - Each CFG_x -> next CFG on `done`.
  - CFG_RND -> WAIT_INT on `done`.
  - WAIT_INT -> RD_L when `INT_ff2`=1.
  - RD_L -> RD_H on `done`.
  - RD_H -> WAIT_INT on `done`.
- Commands issued in order:
  - CFG_INT 16'h0D02
  - CFG_ACC 16'h1053
  - CFG_GYR 16'h1150
  - CFG_RND 16'h1460
  - RD_L 16'hA600
  - RD_H 16'hA700
- On entry to each transaction state, `cmd` is loaded and `wrt` is pulsed for exactly one clock. `cmd` holds that value until the matching `done`.
- RD_L `done`: capture `rd_data[7:0]` into a low-byte holding register.
- RD_H `done`: `yaw_rt` <= {rd_data[7:0], low_hold}; `vld` pulses.
- `setup_done` sets on the CFG_RND `done` and stays high.
- INT high before WAIT_INT is ignored. It is serviced on WAIT_INT entry if it is still high.
- `done` arriving in INIT_WAIT or WAIT_INT, or a second `done` before a new `wrt`, is ignored.

## Timing
- Reset values: `wrt`=0, `cmd`=16'h0000, `setup_done`=0, `yaw_rt`=16'h0000, `vld`=0. State is INIT_WAIT, timer is 0, synchronizer flops are 0.
- First `wrt` occurs 2^16+1 clocks after reset is released (2^10+1 with FAST_SIM).
- `wrt` is registered: it asserts the clock after state entry. Consecutive transactions are separated by at least 1 idle clock after `done`.
- INT-to-`wrt` latency: 3 clocks from the first INT-high rising edge sample (2 synchronizer clocks + 1 registered output).
- `vld` and the new `yaw_rt` appear together, 1 clock after the RD_H `done`.
- `setup_done` rises 1 clock after the CFG_RND `done`.
- Reset mid-transaction: the next edge returns to INIT_WAIT with all outputs at reset values. No further `done` is honored until a new `wrt`.

## Test plan
- FAST_SIM=1, no INT: after reset, the `wrt` pulses carry `cmd` 16'h0D02, 16'h1053, 16'h1150, 16'h1460 in order. The first `wrt` is at clock 1025. `setup_done` rises 1 clock after the 4th `done`.
- SPI model returning 8'h34 for reg A6 and 8'h12 for reg A7, INT raised once after setup: one `vld` pulse with `yaw_rt`=16'h1234. Exactly two read `wrt`s occur (A600 then A700).
- INT held high from reset onward: no read issued before `setup_done`. The first read `wrt` comes 1 clock after WAIT_INT entry.
- Delay `done` by 200 clocks: `cmd` stays stable and `wrt` does not re-pulse during the wait. A spurious extra `done` in WAIT_INT causes no state change.
- Return A6=8'hFF and A7=8'h80 on repeated INT: `yaw_rt`=16'h80FF (negative). One `vld` per INT service.
- Assert `rst` while RD_H is awaiting `done`: the next clock shows `wrt`=0, `setup_done`=0, `yaw_rt`=0. The full config sequence repeats.

Source files
------------

// File: rtl/inert_intf.sv
// Inertial front end: waits for NEMO power-up, writes its four configuration
// registers over SPI, then reads the 16-bit yaw rate on every data-ready interrupt.
module inert_intf #(
   parameter bit FAST_SIM = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic        setup_done,
   output logic [15:0] yaw_rt,
   output logic        vld
);

   typedef enum logic [2:0] {
      INIT_WAIT, CFG_INT, CFG_ACC, CFG_GYR, CFG_RND, WAIT_INT, RD_L, RD_H
   } state_t;

   state_t      r_state;
   logic [15:0] r_timer;
   logic        r_int_ff1;
   logic        r_int_ff2;
   logic        r_issue;      // launch this state's command on the next clock
   logic        r_armed;      // a wrt is outstanding, so the next done belongs to it
   logic [7:0]  r_low_hold;
   logic        r_wrt;
   logic [15:0] r_cmd;
   logic        r_setup_done;
   logic [15:0] r_yaw_rt;
   logic        r_vld;

   logic        w_term;
   logic        w_done_ok;
   logic        w_unused;

   function automatic logic [15:0] cmd_for(input state_t s);
      case (s)
         CFG_INT: cmd_for = 16'h0D02;
         CFG_ACC: cmd_for = 16'h1053;
         CFG_GYR: cmd_for = 16'h1150;
         CFG_RND: cmd_for = 16'h1460;
         RD_L:    cmd_for = 16'hA600;
         RD_H:    cmd_for = 16'hA700;
         default: cmd_for = 16'h0000;
      endcase
   endfunction

   assign w_term    = FAST_SIM ? (&r_timer[9:0]) : (&r_timer);
   assign w_done_ok = done & r_armed;
   assign w_unused  = ^rd_data[15:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= INIT_WAIT;
         r_timer      <= 16'h0000;
         r_int_ff1    <= 1'b0;
         r_int_ff2    <= 1'b0;
         r_issue      <= 1'b0;
         r_armed      <= 1'b0;
         r_low_hold   <= 8'h00;
         r_wrt        <= 1'b0;
         r_cmd        <= 16'h0000;
         r_setup_done <= 1'b0;
         r_yaw_rt     <= 16'h0000;
         r_vld        <= 1'b0;
      end else begin
         r_int_ff1 <= INT;
         r_int_ff2 <= r_int_ff1;
         r_wrt     <= 1'b0;
         r_vld     <= 1'b0;

         if (r_issue) begin
            r_wrt   <= 1'b1;
            r_cmd   <= cmd_for(r_state);
            r_issue <= 1'b0;
            r_armed <= 1'b1;
         end

         case (r_state)
            INIT_WAIT: begin
               r_timer <= r_timer + 16'd1;
               if (w_term) begin
                  r_state <= CFG_INT;
                  r_issue <= 1'b1;
               end
            end
            CFG_INT, CFG_ACC, CFG_GYR: begin
               if (w_done_ok) begin
                  r_armed <= 1'b0;
                  r_issue <= 1'b1;
                  r_state <= (r_state == CFG_INT) ? CFG_ACC :
                             (r_state == CFG_ACC) ? CFG_GYR : CFG_RND;
               end
            end
            CFG_RND: begin
               if (w_done_ok) begin
                  r_armed      <= 1'b0;
                  r_setup_done <= 1'b1;
                  r_state      <= WAIT_INT;
               end
            end
            WAIT_INT: begin
               // Read launches on the transition itself to keep INT-to-wrt at 3 clocks.
               if (r_int_ff2) begin
                  r_state <= RD_L;
                  r_wrt   <= 1'b1;
                  r_cmd   <= cmd_for(RD_L);
                  r_armed <= 1'b1;
               end
            end
            RD_L: begin
               if (w_done_ok) begin
                  r_armed    <= 1'b0;
                  r_low_hold <= rd_data[7:0];
                  r_issue    <= 1'b1;
                  r_state    <= RD_H;
               end
            end
            RD_H: begin
               if (w_done_ok) begin
                  r_armed  <= 1'b0;
                  r_yaw_rt <= {rd_data[7:0], r_low_hold};
                  r_vld    <= 1'b1;
                  r_state  <= WAIT_INT;
               end
            end
            default: r_state <= INIT_WAIT;
         endcase
      end
   end

   assign wrt        = r_wrt;
   assign cmd        = r_cmd;
   assign setup_done = r_setup_done;
   assign yaw_rt     = r_yaw_rt;
   assign vld        = r_vld;

endmodule
